// File: rtl/pwm_fader.sv
// Multi-channel PWM with per-channel linear fade toward a commanded duty; shared slot counter and fade divider.
// PWM_OUT is registered one cycle behind counter/act; CMD_READY drops for exactly one cycle after every accept.
module pwm_fader #(
    parameter int CHANNELS   = 3,
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 188,
    parameter int STEP_DIV   = 375000,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [CW-1:0]       CMD_CH,
    input  logic [WIDTH-1:0]    CMD_TARGET,
    input  logic                CMD_INSTANT,
    output logic [CHANNELS-1:0] PWM_OUT,
    output logic [CHANNELS-1:0] BUSY,
    output logic                PERIOD_START,
    output logic                ERR
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0]    DIV_LAST = DW'(STEP_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CW:0]      CH_LIM   = (CW + 1)'(CHANNELS);

    typedef struct packed {
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] act;
    } ch_t;

    logic [PW-1:0]       pre;
    logic [DW-1:0]       div;
    logic [WIDTH-1:0]    cnt;
    logic                slot_tick;
    logic                fade_tick;
    logic                period_start;
    logic                accept;
    logic                ch_ok;
    logic                ready_q;
    logic                err_q;
    logic [CHANNELS-1:0] on_vec;
    logic [CHANNELS-1:0] pwm_q;

    assign slot_tick    = (pre == PRE_LAST);
    assign fade_tick    = (div == DIV_LAST);
    assign period_start = slot_tick && (cnt == CNT_MAX);
    assign accept       = CMD_VALID && ready_q;
    assign ch_ok        = ({1'b0, CMD_CH} < CH_LIM);

    // Timebase runs free of commands so fades and periods keep a fixed cadence.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre <= '0;
            div <= '0;
            cnt <= '0;
        end else begin
            pre <= slot_tick ? '0 : pre + PW'(1);
            div <= fade_tick ? '0 : div + DW'(1);
            if (slot_tick) begin
                cnt <= cnt + ONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            pwm_q   <= {CHANNELS{ACTIVE_LOW}};
        end else begin
            ready_q <= !accept;
            err_q   <= err_q || (accept && !ch_ok);
            pwm_q   <= on_vec ^ {CHANNELS{ACTIVE_LOW}};
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [CW-1:0] IDX = CW'(i);
        ch_t              st;
        logic             hit;
        logic [WIDTH-1:0] tgt_nxt;
        logic [WIDTH-1:0] stepped;

        assign hit     = accept && ch_ok && (CMD_CH == IDX);
        assign tgt_nxt = hit ? CMD_TARGET : st.target;

        // A fade tick coinciding with a new target steps toward the new one.
        always_comb begin
            stepped = st.cur;
            if (st.cur < tgt_nxt) begin
                stepped = st.cur + ONE;
            end else if (st.cur > tgt_nxt) begin
                stepped = st.cur - ONE;
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                st <= '0;
            end else begin
                st.target <= tgt_nxt;
                if (hit && CMD_INSTANT) begin
                    st.cur <= CMD_TARGET;
                end else if (fade_tick) begin
                    st.cur <= stepped;
                end
                if (period_start) begin
                    st.act <= st.cur;
                end
            end
        end

        // Full-scale duty saturates so the top code has no one-slot gap.
        assign on_vec[i] = (st.act == CNT_MAX) || (cnt < st.act);
        assign BUSY[i]   = (st.cur != st.target);
    end

    assign CMD_READY    = ready_q;
    assign ERR          = err_q;
    assign PWM_OUT      = pwm_q;
    assign PERIOD_START = period_start;
endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent PWM channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 8: PWM resolution in bits (2..16); duty and counter width.
REQ-003 SHALL have parameter PRESCALE, default 188: CLK cycles per PWM slot (>=1).
REQ-004 SHALL have parameter STEP_DIV, default 375000: CLK cycles per fade step (>=1).
REQ-005 SHALL have parameter ACTIVE_LOW, default 1: 1 = PWM_OUT driven low when channel active.
REQ-006 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port CMD_VALID  input  1  command request.
REQ-009 SHALL have port CMD_READY  output  1  command accept; transfer when CMD_VALID && CMD_READY.
REQ-010 SHALL have port CMD_CH  input  max(1,clog2(CHANNELS))  target channel index.
REQ-011 SHALL have port CMD_TARGET  input  WIDTH  target duty.
REQ-012 SHALL have port CMD_INSTANT  input  1  1 = jump to target, 0 = fade.
REQ-013 SHALL have port PWM_OUT  output  CHANNELS  per-channel PWM, polarity per ACTIVE_LOW.
REQ-014 SHALL have port BUSY  output  CHANNELS  bit i high while channel i is fading.
REQ-015 SHALL have port PERIOD_START  output  1  one-cycle pulse at each PWM period start.
REQ-016 SHALL have port ERR  output  1  sticky out-of-range-command flag.

Function
REQ-017 Prescaler SHALL count 0..PRESCALE-1 and wrap; slot tick asserted in the cycle it equals PRESCALE-1.
REQ-018 PWM counter (WIDTH bits, shared) SHALL increment on slot tick, wrapping 2^WIDTH-1 -> 0.
REQ-019 PERIOD_START SHALL pulse for one cycle in the cycle the PWM counter is loaded with 0 by a wrap.
REQ-020 Per channel SHALL hold registers target, cur (fade value) and act (applied duty), all WIDTH bits.
REQ-021 act SHALL load cur only on the PERIOD_START cycle; mid-period duty changes never alter the running period.
REQ-022 Channel active SHALL equal (counter < act), except act = 2^WIDTH-1 is active in every slot; act = 0 is never active.
REQ-023 PWM_OUT[i] SHALL be registered: ~active if ACTIVE_LOW, else active; one CLK latency from counter/act.
REQ-024 Fade divider SHALL count 0..STEP_DIV-1 independently of PWM; fade tick in the cycle it equals STEP_DIV-1.
REQ-025 On fade tick each channel with cur != target SHALL move cur by exactly 1 toward target; no overshoot, no wrap.
REQ-026 BUSY[i] SHALL equal (cur[i] != target[i]).
REQ-027 Accepted command, CMD_INSTANT=1: target and cur of CMD_CH SHALL both load CMD_TARGET next cycle.
REQ-028 Accepted command, CMD_INSTANT=0: target loads CMD_TARGET; cur unchanged except by fade.
REQ-029 Command and fade tick on same channel, same cycle: non-instant SHALL step cur toward the new target; instant load wins over step.
REQ-030 CMD_READY SHALL deassert for exactly the one cycle after each acceptance (max one command per two cycles), otherwise high.
REQ-031 CMD_CH >= CHANNELS SHALL be accepted, change no channel state, and set ERR.
REQ-032 Commands SHALL not disturb prescaler, PWM counter or fade divider.

Reset
REQ-033 While RST high: all counters, target, cur, act = 0; PWM_OUT = inactive level (all ones if ACTIVE_LOW); BUSY, PERIOD_START, ERR, CMD_READY = 0; effective immediately, asynchronously.
REQ-034 CMD_READY SHALL rise on the first CLK edge after RST deasserts; ERR is cleared only by RST.

Verification
REQ-035 WIDTH=4, PRESCALE=1: instant target 4 on ch0 -> PWM_OUT[0] active for counter 0..3 of 16 each period, first from next PERIOD_START.
REQ-036 Duty 0 -> ch never active; duty 15 (WIDTH=4) -> active in all 16 slots, no one-slot gap.
REQ-037 STEP_DIV=4: non-instant target 3 from 0 -> cur steps 1,2,3 on three fade ticks (12 cycles), BUSY[0] falls with last step.
REQ-038 CHANNELS=3: CMD_CH=3 -> accepted, ERR=1 stays set, no BUSY/PWM change; cleared only by RST.
REQ-039 CMD_VALID held two cycles -> one accept, CMD_READY low one cycle, second command accepted on third cycle.
REQ-040 RST asserted mid-fade between CLK edges -> PWM_OUT inactive and BUSY=0 immediately; after release all channels restart at duty 0.
